usb_dev_txn_fsm: RTL and testbench
==================================

Name: usb_dev_txn_fsm

Overview:
- Device-side (function-end) transaction sequencer for the USB-style link; the counterpart of the host top-level FSM.
- Waits for a received token, then handles the transaction in one of two directions:
  - OUT: receives data, replies ACK or NAK.
  - IN: sends data, waits for the host handshake, and retries on failure.
- Drives the existing token/data/handshake receiver and data/handshake sender sub-FSMs through start/done strobes and an 8-bit PID bus.

Parameters:
- MAX_RETRY, 8: number of failed attempts per transaction before the transaction is abandoned (range 1..15).
- HAND_TIMEOUT, 255: cycles to wait in WAIT_HAND for any handshake before the attempt counts as failed (8-bit counter).

Ports:
- clk  in  1  system clock
- rst_l  in  1  asynchronous active-low reset
- r_token_done  in  1  token receiver finished (1-cycle pulse)
- r_token_ok  in  1  token address/CRC valid; qualified by r_token_done
- r_token_pid  in  8  received token PID; qualified by r_token_done
- r_data_start  out  1  start data receiver (1-cycle pulse)
- r_data_finish  in  1  data receiver finished
- r_data_success  in  1  received data good; qualified by r_data_finish
- r_data_fail  in  1  data receive error/timeout (1-cycle pulse)
- start_send_data  out  1  start data sender (1-cycle pulse)
- done_send_data  in  1  data sender finished
- start_send_hand  out  1  start handshake sender (1-cycle pulse)
- done_send_hand  in  1  handshake sender finished
- pid  out  8  PID for the sender currently started
- r_hand  out  1  start handshake receiver (1-cycle pulse)
- receive  in  1  handshake packet received
- ack  in  1  received handshake is ACK; qualified by receive
- nak  in  1  received handshake is NAK; qualified by receive
- r_hand_fail  in  1  handshake receive error
- txn_dir  out  1  1 = IN (device sends), 0 = OUT; valid while busy
- busy  out  1  transaction in progress
- txn_done  out  1  transaction ended (1-cycle pulse)
- txn_success  out  1  qualifies txn_done; 1 = completed with ACK

Behaviour:
- PID encodings (8-bit, as used on the link):
  - OUT = 8'b1000_0111
  - IN = 8'b1001_0110
  - DATA0 = 8'b1100_0011
  - DATA1 = 8'b1101_0010
  - ACK = 8'b0100_1011
  - NAK = 8'b0101_1010
- Reset: state IDLE. All pulse outputs are 0; busy, txn_dir, txn_success are 0; pid = 8'h00; retry and timeout counters are 0.
- All outputs are registered. Each start/pulse output is asserted for exactly 1 cycle, in the cycle after the triggering input.
- pid is loaded in the same cycle as its start pulse and held until the next start.
- States:
  - IDLE:
    - On r_token_done with r_token_ok and pid = OUT: go to RECV_DATA; pulse r_data_start; txn_dir = 0; busy = 1.
    - On pid = IN: go to SEND_DATA; pulse start_send_data with pid = DATA0; txn_dir = 1; busy = 1.
    - Any other PID, or r_token_ok = 0: ignore and stay in IDLE.
  - RECV_DATA:
    - r_data_finish with r_data_success: go to SEND_HAND with pid = ACK; ok flag set.
    - r_data_fail: increment retry. If the new count equals MAX_RETRY, abort. Otherwise go to SEND_HAND with pid = NAK.
    - If r_data_fail and r_data_finish arrive in the same cycle, r_data_fail wins.
  - SEND_HAND:
    - On done_send_hand with ACK sent: go to IDLE; pulse txn_done with txn_success = 1.
    - On done_send_hand with NAK sent: go to RECV_DATA and pulse r_data_start.
  - SEND_DATA: on done_send_data, go to WAIT_HAND; pulse r_hand; clear the timeout counter.
  - WAIT_HAND:
    - receive with ack: success, go to IDLE.
    - receive with nak, or r_hand_fail, or timeout counter reaching HAND_TIMEOUT: increment retry. If the new count equals MAX_RETRY, abort. Otherwise go to SEND_DATA, re-pulsing start_send_data with the same pid.
    - If ack and a failure condition coincide, the failure wins.
- Abort: go to IDLE; pulse txn_done with txn_success = 0.
- Retry counter is 4-bit, cleared in IDLE; it never wraps because it is bounded by MAX_RETRY.
- Tokens arriving while busy are ignored.
- rst_l asserted mid-transaction: immediate return to reset values; no txn_done is generated.

Optional Feature:
- Macro USB_DATA_TOGGLE_EN.
- When defined:
  - A toggle bit, reset to 0, selects DATA0/DATA1 for IN data.
  - The bit flips on each successful IN transaction only; retries resend the same PID.
  - Output data_toggle (1 bit) exposes the current value for the OUT-side receiver check.
- When undefined: IN data always uses DATA0, and there is no data_toggle port.

Test Plan:
- OUT token (pid 8'b1000_0111, ok = 1), then r_data_finish with success → start_send_hand with pid 8'b0100_1011; after done_send_hand, txn_done = 1 and txn_success = 1.
- OUT token, r_data_fail twice, then success → two NAK handshakes (8'b0101_1010), r_data_start pulsed 3 times, then ACK and success.
- IN token (8'b1001_0110) → start_send_data with pid 8'b1100_0011; done_send_data → r_hand; receive + ack → txn_success = 1.
- IN with MAX_RETRY = 8 and nak on every attempt → start_send_data pulsed 8 times, then txn_done with txn_success = 0.
- IN with no handshake and HAND_TIMEOUT = 255 → retry issued exactly 255 cycles after r_hand; rst_l low mid-WAIT_HAND → busy = 0 next cycle with no txn_done.
- With USB_DATA_TOGGLE_EN: two successful INs → pids DATA0 then DATA1 (8'b1101_0010); a NAK retry resends the same PID.

Source files
------------

// File: rtl/usb_dev_txn_fsm_if.sv
// usb_dev_txn_fsm_if
//   Bundle of the strobes and buses between the device transaction sequencer
//   and the packet receiver/sender sub-FSMs.
//   master : the sequencer (usb_dev_txn_fsm)
//   slave  : the receiver/sender side (sub-FSMs, or a testbench)
//   Signals:
//     token receiver   : r_token_done, r_token_ok, r_token_pid[7:0]
//     data receiver    : r_data_start, r_data_finish, r_data_success, r_data_fail
//     data sender      : start_send_data, done_send_data
//     handshake sender : start_send_hand, done_send_hand
//     handshake recv   : r_hand, receive, ack, nak, r_hand_fail
//     shared           : pid[7:0] (PID for the sender being started)
//     status           : txn_dir, busy, txn_done, txn_success
//   Macro USB_DATA_TOGGLE_EN adds data_toggle (current IN DATA0/DATA1 select).
interface usb_dev_txn_fsm_if;
  logic       r_token_done;
  logic       r_token_ok;
  logic [7:0] r_token_pid;
  logic       r_data_start;
  logic       r_data_finish;
  logic       r_data_success;
  logic       r_data_fail;
  logic       start_send_data;
  logic       done_send_data;
  logic       start_send_hand;
  logic       done_send_hand;
  logic [7:0] pid;
  logic       r_hand;
  logic       receive;
  logic       ack;
  logic       nak;
  logic       r_hand_fail;
  logic       txn_dir;
  logic       busy;
  logic       txn_done;
  logic       txn_success;
`ifdef USB_DATA_TOGGLE_EN
  logic       data_toggle;
`endif

  modport master (
    input  r_token_done, r_token_ok, r_token_pid,
    input  r_data_finish, r_data_success, r_data_fail,
    input  done_send_data, done_send_hand,
    input  receive, ack, nak, r_hand_fail,
    output r_data_start, start_send_data, start_send_hand, pid, r_hand,
    output txn_dir, busy, txn_done, txn_success
`ifdef USB_DATA_TOGGLE_EN
    , output data_toggle
`endif
  );

  modport slave (
    output r_token_done, r_token_ok, r_token_pid,
    output r_data_finish, r_data_success, r_data_fail,
    output done_send_data, done_send_hand,
    output receive, ack, nak, r_hand_fail,
    input  r_data_start, start_send_data, start_send_hand, pid, r_hand,
    input  txn_dir, busy, txn_done, txn_success
`ifdef USB_DATA_TOGGLE_EN
    , input data_toggle
`endif
  );
endinterface

// File: rtl/usb_dev_txn_fsm.sv
// usb_dev_txn_fsm
//   Device-side transaction sequencer. Waits for a valid OUT or IN token and
//   then runs the transaction by strobing the receiver/sender sub-FSMs:
//     OUT : receive data, answer ACK (good) or NAK (bad, then receive again)
//     IN  : send data, wait for the host handshake, resend on NAK/error/timeout
//   A transaction is abandoned after MAX_RETRY failed attempts.
// Ports:
//   clk    : system clock
//   rst_l  : asynchronous active-low reset
//   bus    : usb_dev_txn_fsm_if.master (strobes, PID bus, status outputs)
// Parameters:
//   MAX_RETRY    : failed attempts before abort (1..15)
//   HAND_TIMEOUT : cycles waited for a handshake before an IN attempt fails
// Optional feature macro USB_DATA_TOGGLE_EN:
//   IN data alternates DATA0/DATA1 per successful IN transaction and the
//   current toggle is exported as bus.data_toggle. Without it IN data is DATA0.
module usb_dev_txn_fsm #(
  parameter int MAX_RETRY    = 8,
  parameter int HAND_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_l,
  usb_dev_txn_fsm_if.master bus
);

  localparam logic [7:0] PID_OUT   = 8'b1000_0111;
  localparam logic [7:0] PID_IN    = 8'b1001_0110;
  localparam logic [7:0] PID_DATA0 = 8'b1100_0011;
  localparam logic [7:0] PID_DATA1 = 8'b1101_0010;
  localparam logic [7:0] PID_ACK   = 8'b0100_1011;
  localparam logic [7:0] PID_NAK   = 8'b0101_1010;

  typedef enum logic [2:0] {
    IDLE,
    RECV_DATA,
    SEND_HAND,
    SEND_DATA,
    WAIT_HAND
  } state_t;

  state_t     state;
  logic [3:0] retry;
  logic [7:0] tcnt;
  logic       hand_ok;

  logic       r_data_start_q;
  logic       start_send_data_q;
  logic       start_send_hand_q;
  logic       r_hand_q;
  logic [7:0] pid_q;
  logic       txn_dir_q;
  logic       busy_q;
  logic       txn_done_q;
  logic       txn_success_q;

  logic       tok_out;
  logic       tok_in;
  logic       data_bad;
  logic       hand_timeout;
  logic       hand_fail;
  logic       retry_last;
  logic [7:0] in_pid;

  assign tok_out = bus.r_token_done & bus.r_token_ok & (bus.r_token_pid == PID_OUT);
  assign tok_in  = bus.r_token_done & bus.r_token_ok & (bus.r_token_pid == PID_IN);

  // A finish that is not flagged good is treated like a receive error, so the
  // host is NAKed rather than the sequencer waiting forever. r_data_fail
  // therefore dominates a coincident finish.
  assign data_bad = bus.r_data_fail | (bus.r_data_finish & ~bus.r_data_success);

  // The attempt fails on the cycle the count would reach HAND_TIMEOUT, which
  // puts the resend strobe exactly HAND_TIMEOUT cycles after r_hand.
  assign hand_timeout = ((tcnt + 8'd1) == 8'(HAND_TIMEOUT));
  assign hand_fail    = (bus.receive & bus.nak) | bus.r_hand_fail | hand_timeout;

  // True when the failure being handled now is the last one allowed.
  assign retry_last = ((retry + 4'd1) == 4'(MAX_RETRY));

`ifdef USB_DATA_TOGGLE_EN
  logic toggle;
  assign in_pid          = toggle ? PID_DATA1 : PID_DATA0;
  assign bus.data_toggle = toggle;
`else
  assign in_pid = PID_DATA0;
`endif

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state             <= IDLE;
      retry             <= 4'd0;
      tcnt              <= 8'd0;
      hand_ok           <= 1'b0;
      r_data_start_q    <= 1'b0;
      start_send_data_q <= 1'b0;
      start_send_hand_q <= 1'b0;
      r_hand_q          <= 1'b0;
      pid_q             <= 8'h00;
      txn_dir_q         <= 1'b0;
      busy_q            <= 1'b0;
      txn_done_q        <= 1'b0;
      txn_success_q     <= 1'b0;
`ifdef USB_DATA_TOGGLE_EN
      toggle            <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      r_data_start_q    <= 1'b0;
      start_send_data_q <= 1'b0;
      start_send_hand_q <= 1'b0;
      r_hand_q          <= 1'b0;
      txn_done_q        <= 1'b0;

      case (state)
        IDLE: begin
          retry <= 4'd0;
          tcnt  <= 8'd0;
          if (tok_out) begin
            state          <= RECV_DATA;
            r_data_start_q <= 1'b1;
            txn_dir_q      <= 1'b0;
            busy_q         <= 1'b1;
          end else if (tok_in) begin
            state             <= SEND_DATA;
            start_send_data_q <= 1'b1;
            pid_q             <= in_pid;
            txn_dir_q         <= 1'b1;
            busy_q            <= 1'b1;
          end
        end

        RECV_DATA: begin
          if (data_bad) begin
            retry <= retry + 4'd1;
            if (retry_last) begin
              state         <= IDLE;
              busy_q        <= 1'b0;
              txn_done_q    <= 1'b1;
              txn_success_q <= 1'b0;
            end else begin
              state             <= SEND_HAND;
              start_send_hand_q <= 1'b1;
              pid_q             <= PID_NAK;
              hand_ok           <= 1'b0;
            end
          end else if (bus.r_data_finish) begin
            state             <= SEND_HAND;
            start_send_hand_q <= 1'b1;
            pid_q             <= PID_ACK;
            hand_ok           <= 1'b1;
          end
        end

        SEND_HAND: begin
          if (bus.done_send_hand) begin
            if (hand_ok) begin
              state         <= IDLE;
              busy_q        <= 1'b0;
              txn_done_q    <= 1'b1;
              txn_success_q <= 1'b1;
            end else begin
              state          <= RECV_DATA;
              r_data_start_q <= 1'b1;
            end
          end
        end

        SEND_DATA: begin
          if (bus.done_send_data) begin
            state    <= WAIT_HAND;
            r_hand_q <= 1'b1;
            tcnt     <= 8'd0;
          end
        end

        WAIT_HAND: begin
          if (hand_fail) begin
            retry <= retry + 4'd1;
            if (retry_last) begin
              state         <= IDLE;
              busy_q        <= 1'b0;
              txn_done_q    <= 1'b1;
              txn_success_q <= 1'b0;
            end else begin
              // pid still holds this transaction's DATAx, so the resend
              // carries the same PID.
              state             <= SEND_DATA;
              start_send_data_q <= 1'b1;
            end
          end else if (bus.receive && bus.ack) begin
            state         <= IDLE;
            busy_q        <= 1'b0;
            txn_done_q    <= 1'b1;
            txn_success_q <= 1'b1;
`ifdef USB_DATA_TOGGLE_EN
            toggle        <= ~toggle;
`endif
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.r_data_start    = r_data_start_q;
  assign bus.start_send_data = start_send_data_q;
  assign bus.start_send_hand = start_send_hand_q;
  assign bus.r_hand          = r_hand_q;
  assign bus.pid             = pid_q;
  assign bus.txn_dir         = txn_dir_q;
  assign bus.busy            = busy_q;
  assign bus.txn_done        = txn_done_q;
  assign bus.txn_success     = txn_success_q;

endmodule

// File: tb/tb_usb_dev_txn_fsm.sv
// tb_usb_dev_txn_fsm
//   Directed bench for usb_dev_txn_fsm. The stimulus process plays the role of
//   the receiver/sender sub-FSMs and pushes each expected DUT strobe into a
//   scoreboard queue; a monitor process pops and compares whenever a strobe
//   appears. Optional build macro: USB_DATA_TOGGLE_EN.
module tb_usb_dev_txn_fsm;

  localparam logic [7:0] P_OUT   = 8'b1000_0111;
  localparam logic [7:0] P_IN    = 8'b1001_0110;
  localparam logic [7:0] P_DATA0 = 8'b1100_0011;
  localparam logic [7:0] P_DATA1 = 8'b1101_0010;
  localparam logic [7:0] P_ACK   = 8'b0100_1011;
  localparam logic [7:0] P_NAK   = 8'b0101_1010;

  // Strobe kinds tracked by the scoreboard.
  localparam int K_RDS = 0;  // r_data_start
  localparam int K_SD  = 1;  // start_send_data (val = pid)
  localparam int K_SH  = 2;  // start_send_hand (val = pid)
  localparam int K_RH  = 3;  // r_hand
  localparam int K_TD  = 4;  // txn_done (val = txn_success)

  typedef struct {
    int         kind;
    logic [7:0] val;
    int         gap;   // required cycles since previous strobe, -1 = any
  } exp_t;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  usb_dev_txn_fsm_if bus();

  usb_dev_txn_fsm #(.MAX_RETRY(8), .HAND_TIMEOUT(255)) dut (
    .clk  (clk),
    .rst_l(rst_l),
    .bus  (bus)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
`ifdef USB_DATA_TOGGLE_EN
  logic tog_m = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic seen(input int k);
    case (k)
      K_RDS:   return bus.r_data_start;
      K_SD:    return bus.start_send_data;
      K_SH:    return bus.start_send_hand;
      K_RH:    return bus.r_hand;
      default: return bus.txn_done;
    endcase
  endfunction

  function automatic logic [7:0] val_of(input int k);
    if (k == K_SD || k == K_SH) return bus.pid;
    if (k == K_TD) return {7'b0, bus.txn_success};
    return 8'h00;
  endfunction

  function automatic logic [7:0] exp_in_pid();
`ifdef USB_DATA_TOGGLE_EN
    return tog_m ? P_DATA1 : P_DATA0;
`else
    return P_DATA0;
`endif
  endfunction

  task automatic in_succeeded();
`ifdef USB_DATA_TOGGLE_EN
    tog_m = ~tog_m;
`endif
  endtask

  // Monitor: compares every strobe against the head of the scoreboard.
  initial begin
    int   cyc;
    int   last_cyc;
    exp_t e;
    cyc = 0;
    last_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 5; k++) begin
        if (seen(k) === 1'b1) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_strobe: got strobe kind %0d, required none", k);
          end else begin
            e = sb.pop_front();
            check($sformatf("strobe_kind_c%0d", cyc), k, e.kind);
            check($sformatf("strobe_val_k%0d_c%0d", k, cyc), {24'b0, val_of(k)}, {24'b0, e.val});
            if (e.gap >= 0)
              check($sformatf("strobe_gap_k%0d", k), cyc - last_cyc, e.gap);
          end
          last_cyc = cyc;
        end
      end
    end
  end

  task automatic push(input int k, input logic [7:0] v, input int g = -1);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.gap  = g;
    sb.push_back(e);
  endtask

  // Returns on the falling edge where strobe k is seen, bounded.
  task automatic wait_evt(input int k, input string what);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 1000 && !got; n++) begin
      @(negedge clk);
      if (seen(k) === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_%s: no strobe in 1000 cycles, required one", what);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic token(input logic [7:0] p, input logic ok);
    bus.r_token_pid = p; bus.r_token_ok = ok; bus.r_token_done = 1'b1;
    step();
    bus.r_token_done = 1'b0; bus.r_token_ok = 1'b0; bus.r_token_pid = 8'h00;
  endtask

  task automatic data_rx(input logic fin, input logic good, input logic fail);
    bus.r_data_finish = fin; bus.r_data_success = good; bus.r_data_fail = fail;
    step();
    bus.r_data_finish = 1'b0; bus.r_data_success = 1'b0; bus.r_data_fail = 1'b0;
  endtask

  task automatic done_hand();
    bus.done_send_hand = 1'b1;
    step();
    bus.done_send_hand = 1'b0;
  endtask

  task automatic done_data();
    bus.done_send_data = 1'b1;
    step();
    bus.done_send_data = 1'b0;
  endtask

  task automatic hand(input logic a, input logic n, input logic f);
    bus.receive = a | n; bus.ack = a; bus.nak = n; bus.r_hand_fail = f;
    step();
    bus.receive = 1'b0; bus.ack = 1'b0; bus.nak = 1'b0; bus.r_hand_fail = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.r_token_done = 1'b0; bus.r_token_ok = 1'b0; bus.r_token_pid = 8'h00;
    bus.r_data_finish = 1'b0; bus.r_data_success = 1'b0; bus.r_data_fail = 1'b0;
    bus.done_send_data = 1'b0; bus.done_send_hand = 1'b0;
    bus.receive = 1'b0; bus.ack = 1'b0; bus.nak = 1'b0; bus.r_hand_fail = 1'b0;

    // Reset state
    idle(3);
    check("rst_busy", bus.busy, 0);
    check("rst_txn_dir", bus.txn_dir, 0);
    check("rst_pid", bus.pid, 0);
    check("rst_txn_success", bus.txn_success, 0);
    check("rst_strobes", {bus.r_data_start, bus.start_send_data, bus.start_send_hand,
                          bus.r_hand, bus.txn_done}, 0);
`ifdef USB_DATA_TOGGLE_EN
    check("rst_toggle", bus.data_toggle, 0);
`endif
    rst_l = 1'b1;
    idle(2);

    // Tokens that must be ignored: non-token PID, and OUT with bad CRC
    token(P_ACK, 1'b1);
    token(P_OUT, 1'b0);
    token(P_IN, 1'b0);
    idle(3);
    check("ignore_busy", bus.busy, 0);

    // OUT, good data, ACK; an IN token while busy is ignored
    push(K_RDS, 8'h00);
    token(P_OUT, 1'b1);
    wait_evt(K_RDS, "out1_rds");
    check("out1_busy", bus.busy, 1);
    check("out1_dir", bus.txn_dir, 0);
    token(P_IN, 1'b1);
    idle(2);
    push(K_SH, P_ACK);
    data_rx(1'b1, 1'b1, 1'b0);
    wait_evt(K_SH, "out1_sh");
    push(K_TD, 8'h01);
    done_hand();
    wait_evt(K_TD, "out1_td");
    check("out1_busy_end", bus.busy, 0);

    // OUT with two receive errors (second coincides with finish): NAK, NAK, ACK
    push(K_RDS, 8'h00);
    token(P_OUT, 1'b1);
    wait_evt(K_RDS, "out2_rds0");
    for (int i = 0; i < 2; i++) begin
      push(K_SH, P_NAK);
      data_rx(i == 1, i == 1, 1'b1);
      wait_evt(K_SH, "out2_nak");
      push(K_RDS, 8'h00);
      done_hand();
      wait_evt(K_RDS, "out2_rds");
    end
    push(K_SH, P_ACK);
    data_rx(1'b1, 1'b1, 1'b0);
    wait_evt(K_SH, "out2_ack");
    push(K_TD, 8'h01);
    done_hand();
    wait_evt(K_TD, "out2_td");

    // IN: first handshake is ack with r_hand_fail (failure wins), then ack
    push(K_SD, exp_in_pid());
    token(P_IN, 1'b1);
    wait_evt(K_SD, "in1_sd");
    check("in1_dir", bus.txn_dir, 1);
    check("in1_busy", bus.busy, 1);
    push(K_RH, 8'h00);
    done_data();
    wait_evt(K_RH, "in1_rh");
    push(K_SD, exp_in_pid());
    hand(1'b1, 1'b0, 1'b1);
    wait_evt(K_SD, "in1_retry");
    push(K_RH, 8'h00);
    done_data();
    wait_evt(K_RH, "in1_rh2");
    push(K_TD, 8'h01);
    hand(1'b1, 1'b0, 1'b0);
    wait_evt(K_TD, "in1_td");
    in_succeeded();
`ifdef USB_DATA_TOGGLE_EN
    check("in1_toggle", bus.data_toggle, tog_m);
`endif

    // IN with NAK on every attempt: 8 sends, then abort
    push(K_SD, exp_in_pid());
    token(P_IN, 1'b1);
    for (int i = 0; i < 8; i++) begin
      wait_evt(K_SD, "in2_sd");
      push(K_RH, 8'h00);
      done_data();
      wait_evt(K_RH, "in2_rh");
      if (i < 7) push(K_SD, exp_in_pid());
      else       push(K_TD, 8'h00);
      hand(1'b0, 1'b1, 1'b0);
    end
    wait_evt(K_TD, "in2_abort");
    check("in2_busy_end", bus.busy, 0);

    // IN with one NAK retry then ACK (resend keeps the PID)
    push(K_SD, exp_in_pid());
    token(P_IN, 1'b1);
    wait_evt(K_SD, "in3_sd");
    push(K_RH, 8'h00);
    done_data();
    wait_evt(K_RH, "in3_rh");
    push(K_SD, exp_in_pid());
    hand(1'b0, 1'b1, 1'b0);
    wait_evt(K_SD, "in3_retry");
    push(K_RH, 8'h00);
    done_data();
    wait_evt(K_RH, "in3_rh2");
    push(K_TD, 8'h01);
    hand(1'b1, 1'b0, 1'b0);
    wait_evt(K_TD, "in3_td");
    in_succeeded();

    // IN with no handshake: resend exactly 255 cycles after r_hand, then
    // reset mid-WAIT_HAND
    push(K_SD, exp_in_pid());
    token(P_IN, 1'b1);
    wait_evt(K_SD, "in4_sd");
    push(K_RH, 8'h00);
    done_data();
    wait_evt(K_RH, "in4_rh");
    push(K_SD, exp_in_pid(), 255);
    wait_evt(K_SD, "in4_timeout");
    push(K_RH, 8'h00);
    done_data();
    wait_evt(K_RH, "in4_rh2");
    idle(5);
    check("in4_busy_pre", bus.busy, 1);
    rst_l = 1'b0;
    #1;
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_done", bus.txn_done, 0);
    check("rst_mid_pid", bus.pid, 0);
    @(negedge clk);
    check("rst_mid_busy2", bus.busy, 0);
    rst_l = 1'b1;
`ifdef USB_DATA_TOGGLE_EN
    tog_m = 1'b0;
    check("rst_mid_toggle", bus.data_toggle, 0);
`endif
    idle(3);
    check("post_rst_busy", bus.busy, 0);

    // A fresh OUT after the reset still works
    push(K_RDS, 8'h00);
    token(P_OUT, 1'b1);
    wait_evt(K_RDS, "out3_rds");
    push(K_SH, P_ACK);
    data_rx(1'b1, 1'b1, 1'b0);
    wait_evt(K_SH, "out3_sh");
    push(K_TD, 8'h01);
    done_hand();
    wait_evt(K_TD, "out3_td");

    idle(4);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
